// File: rtl/pipe_prefix_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_prefix_adder_pkg
// Brief    : KGP carry-code constants and helpers shared by the prefix adder.
// Revision : 1.0  initial release
// ============================================================================
package pipe_prefix_adder_pkg;

  localparam logic [1:0] KGP_KILL = 2'b00;
  localparam logic [1:0] KGP_PROP = 2'b01;
  localparam logic [1:0] KGP_GEN  = 2'b11;

  // The raw {a,b} code 2'b10 means the same thing as 2'b01 (exactly one bit set).
  function automatic logic [1:0] kgp_normalise(input logic [1:0] raw);
    return (raw == 2'b10) ? KGP_PROP : raw;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_prefix_adder_kgp_prefix_cell.sv
`default_nettype none
// ============================================================================
// Module   : kgp_prefix_cell
// Brief    : Combinational KGP prefix combine: hi wins unless it propagates.
// Revision : 1.0  initial release
// ============================================================================
module kgp_prefix_cell
  import pipe_prefix_adder_pkg::*;
(
  input  logic [1:0] hi,
  input  logic [1:0] lo,
  output logic [1:0] y
);

  assign y = (hi == KGP_PROP) ? lo : hi;

endmodule
`default_nettype wire

// File: rtl/pipe_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_prefix_adder
// Brief    : Pipelined Kogge-Stone KGP adder/subtractor, one prefix level per
//            stage, valid/ready on both ends, carry-out and signed overflow.
// Revision : 1.0  initial release
// ============================================================================
module pipe_prefix_adder
  import pipe_prefix_adder_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int LEVELS = int'(clog2(WIDTH));

  // Code index 0 is the carry-in; index i+1 is operand bit i.
  typedef logic [WIDTH:0][1:0] kgp_vec_t;

  logic             w_advance;
  logic [WIDTH-1:0] w_beff;
  kgp_vec_t         w_kgp0;
  kgp_vec_t         w_lvl [LEVELS+1];
  kgp_vec_t         w_fin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  kgp_vec_t         r_kgp [LEVELS+1];
  logic [WIDTH-1:0] r_x   [LEVELS+1];
  logic             r_am  [LEVELS+1];
  logic             r_bm  [LEVELS+1];
  logic             r_v   [LEVELS+1];
  logic [WIDTH:0]   r_sum;
  logic             r_ovf;
  logic             r_out_v;

  assign w_advance = !r_out_v || out_ready;
  assign in_ready  = w_advance && !rst;
  assign w_beff    = sub ? ~b : b;

  always_comb begin
    w_kgp0    = '0;
    w_kgp0[0] = (sub || cin) ? KGP_GEN : KGP_KILL;
    for (int i = 0; i < WIDTH; i++) begin
      w_kgp0[i+1] = kgp_normalise({a[i], w_beff[i]});
    end
  end

  generate
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      kgp_vec_t w_nxt;
      for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
        if (i >= (1 << k)) begin : g_cell
          kgp_prefix_cell u_cell (
            .hi (r_kgp[k][i]),
            .lo (r_kgp[k][i-(1<<k)]),
            .y  (w_nxt[i])
          );
        end else begin : g_pass
          assign w_nxt[i] = r_kgp[k][i];
        end
      end
      assign w_lvl[k] = w_nxt;
    end
  endgenerate

  assign w_lvl[LEVELS] = r_kgp[LEVELS];

  // With WIDTH a power of two the top index spans every bit but not the
  // carry-in, so a residual propagate is resolved against index 0 here.
  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fix
      kgp_prefix_cell u_fix (
        .hi (w_lvl[LEVELS][i]),
        .lo (w_lvl[LEVELS][0]),
        .y  (w_fin[i])
      );
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = (w_fin[i] == KGP_GEN) ^ r_x[LEVELS][i];
    end
    w_sum[WIDTH] = (w_fin[WIDTH] == KGP_GEN);
    w_ovf = (r_am[LEVELS] == r_bm[LEVELS]) && (w_sum[WIDTH-1] != r_am[LEVELS]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        r_v[k]   <= 1'b0;
        r_kgp[k] <= '0;
        r_x[k]   <= '0;
        r_am[k]  <= 1'b0;
        r_bm[k]  <= 1'b0;
      end
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_advance) begin
      r_v[0]   <= in_valid;
      r_kgp[0] <= w_kgp0;
      r_x[0]   <= a ^ w_beff;
      r_am[0]  <= a[WIDTH-1];
      r_bm[0]  <= w_beff[WIDTH-1];
      for (int k = 0; k < LEVELS; k++) begin
        r_v[k+1]   <= r_v[k];
        r_kgp[k+1] <= w_lvl[k];
        r_x[k+1]   <= r_x[k];
        r_am[k+1]  <= r_am[k];
        r_bm[k+1]  <= r_bm[k];
      end
      r_out_v <= r_v[LEVELS];
      r_sum   <= w_sum;
      r_ovf   <= w_ovf;
    end
  end

  assign out_valid = r_out_v;
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_prefix_adder
// Brief    : Self-checking bench: arithmetic reference model plus directed cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_prefix_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, cin8, sub8, ovf8;
  logic [7:0]  a8, b8;
  logic [8:0]  s8;
  logic        iv16, ir16, ov16, or16, cin16, sub16, ovf16;
  logic [15:0] a16, b16;
  logic [16:0] s16;
  logic        iv1, ir1, ov1, or1, cin1, sub1, ovf1;
  logic [0:0]  a1, b1;
  logic [1:0]  s1;

  pipe_prefix_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .ovf(ovf8));
  pipe_prefix_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16), .ovf(ovf16));
  pipe_prefix_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1), .ovf(ovf1));

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic; overflow = signed result out of range.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
    int ua, ub, c, sa, sb, us, ss;
    ua = int'(a);
    ub = sub ? (255 - int'(b)) : int'(b);
    c  = sub ? 1 : int'(cin);
    us = ua + ub + c;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    ss = sa + sb + c;
    return {us[8:0], (ss > 127 || ss < -128)};
  endfunction

  logic [9:0] expq [$];
  logic [8:0] prev_sum;
  logic       prev_ovf;
  bit         prev_stall = 1'b0;

  // Compare process for the 8-bit instance
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      check_eq("in_ready_rule", 32'(ir8), 32'(!ov8 || or8));
      if (prev_stall) begin
        check_eq("hold_valid", 32'(ov8), 32'd1);
        check_eq("hold_sum", 32'({s8, ovf8}), 32'({prev_sum, prev_ovf}));
      end
      if (ov8) begin
        if (expq.size() == 0) begin
          check_eq("spurious_out", 32'(ov8), 32'd0);
        end else begin
          check_eq("model_sum_ovf", 32'({s8, ovf8}), 32'(expq[0]));
          if (or8) begin
            void'(expq.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = ov8 && !or8;
      prev_sum   = s8;
      prev_ovf   = ovf8;
      if (iv8 && ir8) expq.push_back(model8(a8, b8, cin8, sub8));
    end
  end

  task automatic directed(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [16:0] es,
                          input logic eo, input int elat, input string name);
    int lat;
    bit seen;
    logic cur_ov, cur_rdy, cur_ovf;
    logic [16:0] cur_sum;
    @(posedge clk); #1;
    case (sel)
      8:  begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; end
      16: begin iv16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub; end
      default: begin iv1 = 1'b1; a1 = a[0]; b1 = b[0]; cin1 = cin; sub1 = sub; end
    endcase
    @(negedge clk);
    cur_rdy = (sel == 8) ? ir8 : (sel == 16) ? ir16 : ir1;
    check_eq({name, "_in_ready"}, 32'(cur_rdy), 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0; iv16 = 1'b0; iv1 = 1'b0;
    lat = 1;
    seen = 1'b0;
    cur_sum = '0;
    cur_ovf = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      cur_ov  = (sel == 8) ? ov8 : (sel == 16) ? ov16 : ov1;
      cur_sum = (sel == 8) ? 17'(s8) : (sel == 16) ? s16 : 17'(s1);
      cur_ovf = (sel == 8) ? ovf8 : (sel == 16) ? ovf16 : ovf1;
      if (cur_ov) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check_eq({name, "_seen"}, 32'(seen), 32'd1);
    check_eq({name, "_latency"}, 32'(lat), 32'(elat));
    check_eq({name, "_sum"}, 32'(cur_sum), 32'(es));
    check_eq({name, "_ovf"}, 32'(cur_ovf), 32'(eo));
  endtask

  logic [7:0] ra [10];
  logic [7:0] rb [10];
  logic       rc [10];
  logic       rs [10];

  initial begin
    int idx, base, first, cyc;
    bit acc;
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready8", 32'(ir8), 32'd0);
    check_eq("rst_in_ready16", 32'(ir16), 32'd0);
    check_eq("rst_out_valid8", 32'(ov8), 32'd0);
    check_eq("rst_sum8", 32'({s8, ovf8}), 32'd0);
    check_eq("rst_out_valid16", 32'(ov16), 32'd0);
    check_eq("rst_sum16", 32'({s16, ovf16}), 32'd0);
    check_eq("rst_out_valid1", 32'(ov1), 32'd0);
    check_eq("rst_sum1", 32'({s1, ovf1}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed literal cases
    directed(8,  16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0, 5, "add_ff_01");
    directed(8,  16'h007F, 16'h0001, 1'b0, 1'b0, 17'h00080, 1'b1, 5, "add_7f_01");
    directed(8,  16'h0080, 16'h00FF, 1'b1, 1'b0, 17'h00180, 1'b0, 5, "add_80_ff_c");
    directed(8,  16'h0005, 16'h0007, 1'b1, 1'b1, 17'h000FE, 1'b0, 5, "sub_05_07");
    directed(8,  16'h0080, 16'h0001, 1'b0, 1'b1, 17'h0017F, 1'b1, 5, "sub_80_01");
    directed(16, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b0, 6, "w16_ffff_c");
    directed(1,  16'h0001, 16'h0001, 1'b1, 1'b0, 17'h00003, 1'b0, 2, "w1_1_1_c");

    // Ten back-to-back beats with a 4-cycle downstream stall
    for (int i = 0; i < 10; i++) begin
      ra[i] = 8'($urandom); rb[i] = 8'($urandom);
      rc[i] = 1'($urandom); rs[i] = 1'($urandom);
    end
    idx = 0; base = n_out; first = -1; cyc = 0;
    while ((idx < 10 || n_out - base < 10) && cyc < 200) begin
      @(posedge clk); #1;
      if (idx < 10) begin
        iv8 = 1'b1; a8 = ra[idx]; b8 = rb[idx]; cin8 = rc[idx]; sub8 = rs[idx];
      end else iv8 = 1'b0;
      // stall cycles counted from the first result appearing
      or8 = !(first >= 0 && cyc - first >= 3 && cyc - first <= 6);
      @(negedge clk);
      if (!or8) check_eq("stall_in_ready", 32'(ir8), 32'd0);
      acc = iv8 && ir8;
      if (ov8 && first < 0) first = cyc;
      cyc++;
      if (acc) idx++;
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    check_eq("stream_count", 32'(n_out - base), 32'd10);

    // Random valid/ready traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      iv8 = ($urandom_range(0, 9) < 7);
      or8 = ($urandom_range(0, 9) < 7);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("drain_empty", 32'(expq.size()), 32'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1; sub8 = 1'b0;
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", 32'(ir8), 32'd0);
    @(posedge clk); #1;
    check_eq("midrst_out_valid", 32'(ov8), 32'd0);
    check_eq("midrst_sum_ovf", 32'({s8, ovf8}), 32'd0);
    check_eq("midrst_in_ready_after", 32'(ir8), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    directed(8, 16'h0012, 16'h0034, 1'b1, 1'b0, 17'h00047, 1'b0, 5, "post_rst");
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
